dff_en_reg: RTL and testbench

DFF_EN_REG -- requirements
Module: dff_en_reg

---
 rtl/dff_en_reg_pkg.sv | 7 +
 rtl/D_FF.sv | 17 +
 rtl/mux2_1.sv | 11 +
 rtl/dff_en_reg.sv | 48 ++++
 tb/tb_dff_en_reg.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/dff_en_reg_pkg.sv
// Default parameter values shared by the enabled register and its users.
package dff_en_reg_pkg;

    localparam int DEFAULT_WIDTH = 1;
    localparam logic [63:0] DEFAULT_RESET_VAL = 64'h0;

endpackage

// File: rtl/D_FF.sv
// Rising-edge D flip-flop leaf cell with asynchronous active-high reset to 0.
module D_FF (
    output logic q,
    input  logic d,
    input  logic reset,
    input  logic clk
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/mux2_1.sv
// Two-input, one-bit multiplexer leaf cell: out = sel ? i1 : i0.
module mux2_1 (
    output logic out,
    input  logic i0,
    input  logic i1,
    input  logic sel
);

    assign out = sel ? i1 : i0;

endmodule

// File: rtl/dff_en_reg.sv
// WIDTH-bit load-enabled register built from per-bit mux2_1 + D_FF cells,
// with an asynchronous active-high reset to an arbitrary RESET_VAL.
module dff_en_reg
    import dff_en_reg_pkg::*;
#(
    parameter int                 WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]   RESET_VAL = DEFAULT_RESET_VAL[WIDTH-1:0]
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] mux_out;
    logic [WIDTH-1:0] ff_d;
    logic [WIDTH-1:0] ff_q;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            mux2_1 u_mux (
                .out (mux_out[gi]),
                .i0  (q[gi]),
                .i1  (d[gi]),
                .sel (en)
            );

            D_FF u_ff (
                .q     (ff_q[gi]),
                .d     (ff_d[gi]),
                .reset (reset),
                .clk   (clk)
            );

            // The flop always clears to 0; a reset-to-1 bit stores its
            // complement so that the cleared flop reads back as 1.
            if (RESET_VAL[gi]) begin : g_inv
                assign ff_d[gi] = ~mux_out[gi];
                assign q[gi]    = ~ff_q[gi];
            end else begin : g_pass
                assign ff_d[gi] = mux_out[gi];
                assign q[gi]    = ff_q[gi];
            end
        end
    endgenerate

endmodule

// File: tb/tb_dff_en_reg.sv
// Directed self-checking bench for dff_en_reg: a 1-bit default instance and
// an 8-bit instance resetting to 8'hA5.
module tb_dff_en_reg;

    logic       clk;
    logic       reset_a;
    logic [0:0] d_a;
    logic       en_a;
    logic [0:0] q_a;
    logic       reset_b;
    logic [7:0] d_b;
    logic       en_b;
    logic [7:0] q_b;

    int errors = 0;
    int checks = 0;

    dff_en_reg u_dut_a (
        .clk   (clk),
        .reset (reset_a),
        .d     (d_a),
        .en    (en_a),
        .q     (q_a)
    );

    dff_en_reg #(
        .WIDTH     (8),
        .RESET_VAL (8'hA5)
    ) u_dut_b (
        .clk   (clk),
        .reset (reset_b),
        .d     (d_b),
        .en    (en_b),
        .q     (q_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-28s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance to 2 time units after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset_a = 1'b1; d_a = 1'b0; en_a = 1'b0;
        reset_b = 1'b1; d_b = 8'h00; en_b = 1'b0;
        #1;
        check("a_reset_async", {7'h0, q_a}, 8'h00);
        check("b_reset_async", q_b, 8'hA5);

        // Reset held across one edge with en=1 and d=1: must be ignored.
        en_a = 1'b1; d_a = 1'b1;
        tick();
        check("a_reset_over_edge", {7'h0, q_a}, 8'h00);
        reset_a = 1'b0; en_a = 1'b0; d_a = 1'b0;

        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("a_hold0_d0_%0d", i), {7'h0, q_a}, 8'h00);
        end

        d_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("a_hold0_d1_%0d", i), {7'h0, q_a}, 8'h00);
        end

        en_a = 1'b1; d_a = 1'b1;
        #2;
        check("a_no_comb_path", {7'h0, q_a}, 8'h00);
        tick();
        check("a_load1", {7'h0, q_a}, 8'h01);
        tick();
        check("a_load_same", {7'h0, q_a}, 8'h01);
        en_a = 1'b0; d_a = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("a_hold1_%0d", i), {7'h0, q_a}, 8'h01);
        end

        en_a = 1'b1; d_a = 1'b0;
        tick();
        check("a_load0", {7'h0, q_a}, 8'h00);
        en_a = 1'b0; d_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("a_hold0_again_%0d", i), {7'h0, q_a}, 8'h00);
        end

        // 8-bit instance, reset value A5.
        reset_b = 1'b0;
        tick();
        check("b_after_reset", q_b, 8'hA5);
        en_b = 1'b1; d_b = 8'h3C;
        tick();
        check("b_load_3c", q_b, 8'h3C);
        en_b = 1'b0; d_b = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("b_hold_3c_%0d", i), q_b, 8'h3C);
        end

        // Reset pulse strictly between edges.
        #1 reset_b = 1'b1;
        #1 check("b_midcycle_reset", q_b, 8'hA5);
        reset_b = 1'b0;
        #1 check("b_after_pulse", q_b, 8'hA5);

        // Reset held across an edge with a pending load.
        tick();
        reset_b = 1'b1; en_b = 1'b1; d_b = 8'h3C;
        tick();
        check("b_reset_wins_load", q_b, 8'hA5);
        reset_b = 1'b0;
        tick();
        check("b_first_edge_post", q_b, 8'h3C);

        // d toggled between edges: only the value at each edge counts.
        d_b = 8'h11;
        #4 d_b = 8'h22;
        tick();
        check("b_sampled_22", q_b, 8'h22);
        d_b = 8'h33;
        #2 check("b_mid_d_ignored", q_b, 8'h22);
        en_b = 1'b0;
        #1 en_b = 1'b1;
        d_b = 8'h44;
        tick();
        check("b_sampled_44", q_b, 8'h44);
        en_b = 1'b0; d_b = 8'h5A;
        tick();
        check("b_hold_44", q_b, 8'h44);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
